pipe_reg: RTL

Parametrised, handshaked pipeline stage register for the RISC-V core, generalising the fixed ID/EXE latch into a reusable stage for any boundary (IF/ID, ID/EXE, EXE/MEM, MEM/WB). It carries an opaque payload plus the hazard-relevant fields (regWrite, rd/rs1/rs2 addresses) and adds what the plain latch lacks: valid/ready flow control, stall, flush (bubble insertion), an optional skid entry for a registered ready, and saturating stall/flush counters.

---
 rtl/pipe_reg.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/pipe_reg.sv
// -----------------------------------------------------------------------------
// pipe_reg : handshaked pipeline stage register for the RISC-V core.
//
// A reusable stage boundary (IF/ID, ID/EXE, EXE/MEM, MEM/WB). It carries an
// opaque payload plus the hazard-relevant fields (regWrite, rd/rs1/rs2).
// It also provides:
//   - valid/ready flow control,
//   - stall and flush (bubble insertion),
//   - an optional skid entry so that ready can come straight from a flop,
//   - saturating stall and flush counters.
//
// Ports (all state changes on the rising edge of clk_i_PIPE_REG):
//   rst_i_PIPE_REG        in   synchronous, active-low reset
//   valid_i/ready_o       upstream handshake
//   payload_i, regWrite_i, rd/rs1/rs2_addr_i
//                         upstream entry fields
//   valid_o/ready_i       downstream handshake
//   payload_o, regWrite_o, rd/rs1/rs2_addr_o
//                         held entry, all zero when no entry is held
//   stall_i               hazard stall; holds the output entry
//   flush_i               kills every held entry and drops the input
//   stall_cnt_o           cycles a valid output was held back (saturating)
//   flush_cnt_o           flushes that killed at least one entry (saturating)
//
// Parameters:
//   PAYLOAD_W  payload width
//   REGADDR_W  register address width
//   SKID       1 = main + skid entry, registered ready
//              0 = single entry, combinational ready
//   CNT_W      counter width
// -----------------------------------------------------------------------------
module pipe_reg #(
  parameter int PAYLOAD_W = 128,
  parameter int REGADDR_W = 5,
  parameter int SKID      = 1,
  parameter int CNT_W     = 16
) (
  input  logic                 clk_i_PIPE_REG,
  input  logic                 rst_i_PIPE_REG,
  input  logic                 valid_i_PIPE_REG,
  output logic                 ready_o_PIPE_REG,
  input  logic [PAYLOAD_W-1:0] payload_i_PIPE_REG,
  input  logic                 regWrite_i_PIPE_REG,
  input  logic [REGADDR_W-1:0] rd_addr_i_PIPE_REG,
  input  logic [REGADDR_W-1:0] rs1_addr_i_PIPE_REG,
  input  logic [REGADDR_W-1:0] rs2_addr_i_PIPE_REG,
  output logic                 valid_o_PIPE_REG,
  input  logic                 ready_i_PIPE_REG,
  output logic [PAYLOAD_W-1:0] payload_o_PIPE_REG,
  output logic                 regWrite_o_PIPE_REG,
  output logic [REGADDR_W-1:0] rd_addr_o_PIPE_REG,
  output logic [REGADDR_W-1:0] rs1_addr_o_PIPE_REG,
  output logic [REGADDR_W-1:0] rs2_addr_o_PIPE_REG,
  input  logic                 stall_i_PIPE_REG,
  input  logic                 flush_i_PIPE_REG,
  output logic [CNT_W-1:0]     stall_cnt_o_PIPE_REG,
  output logic [CNT_W-1:0]     flush_cnt_o_PIPE_REG
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [PAYLOAD_W-1:0] payload;
    logic                 reg_write;
    logic [REGADDR_W-1:0] rd;
    logic [REGADDR_W-1:0] rs1;
    logic [REGADDR_W-1:0] rs2;
  } entry_t;

  // Local short names.
  logic rst_n;
  logic flush;
  logic stall;
  logic valid_o;
  logic ready_o;
  logic accept;
  logic drain;

  entry_t in_entry;

  state_t           state_q, state_d;
  entry_t           main_q,  main_d;
  entry_t           skid_q,  skid_d;
  logic             ready_q, ready_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  assign rst_n = rst_i_PIPE_REG;
  assign flush = flush_i_PIPE_REG;
  assign stall = stall_i_PIPE_REG;

  assign in_entry.payload   = payload_i_PIPE_REG;
  assign in_entry.reg_write = regWrite_i_PIPE_REG;
  assign in_entry.rd        = rd_addr_i_PIPE_REG;
  assign in_entry.rs1       = rs1_addr_i_PIPE_REG;
  assign in_entry.rs2       = rs2_addr_i_PIPE_REG;

  assign valid_o = (state_q != ST_EMPTY);
  assign drain   = valid_o & ready_i_PIPE_REG & ~stall;

  // Ready is forced low while reset is asserted, so no upstream handshake
  // can appear to complete during reset.
  generate
    if (SKID != 0) begin : g_ready_reg
      // Registered ready: depends only on whether the skid slot is occupied.
      assign ready_o = ready_q & rst_n;
    end else begin : g_ready_comb
      assign ready_o = (~valid_o | drain) & rst_n;
    end
  endgenerate

  assign accept = valid_i_PIPE_REG & ready_o;

  // Next-state and entry movement. The main entry is zeroed whenever the
  // stage goes empty, so the outputs present a clean bubble.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_BUSY;
            main_d  = in_entry;
          end
        end
        ST_BUSY: begin
          if (accept && drain) begin
            main_d = in_entry;
          end else if (accept && (SKID != 0)) begin
            // Output is blocked: park the new entry in the skid slot.
            state_d = ST_FULL;
            skid_d  = in_entry;
          end else if (drain) begin
            state_d = ST_EMPTY;
            main_d  = '0;
          end
        end
        ST_FULL: begin
          if (drain) begin
            state_d = ST_BUSY;
            main_d  = skid_q;
            skid_d  = '0;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase
    end

    ready_d = (state_d != ST_FULL);
  end

  // Saturating counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (valid_o && !drain && !flush && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (flush && (state_q != ST_EMPTY) && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i_PIPE_REG) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      ready_q     <= 1'b1;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      ready_q     <= ready_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign ready_o_PIPE_REG     = ready_o;
  assign valid_o_PIPE_REG     = valid_o;
  assign payload_o_PIPE_REG   = main_q.payload;
  assign regWrite_o_PIPE_REG  = main_q.reg_write & valid_o;
  assign rd_addr_o_PIPE_REG   = main_q.rd;
  assign rs1_addr_o_PIPE_REG  = main_q.rs1;
  assign rs2_addr_o_PIPE_REG  = main_q.rs2;
  assign stall_cnt_o_PIPE_REG = stall_cnt_q;
  assign flush_cnt_o_PIPE_REG = flush_cnt_q;

endmodule
